// File: rtl/sdf_delay_line_ctrl.sv
// Programmable-depth circular delay line built on a 1R1W synchronous-read SRAM.
// Each accepted sample returns exactly depth_reg accepts later, independent of idle gaps.
module sdf_delay_line_ctrl #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 8,
    parameter int MAX_DEPTH = 256
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W:0]   cfg_depth,
    input  logic              cfg_load,
    input  logic              in_en,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_primed,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic              mem_wen,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [ADDR_W-1:0] mem_raddr,
    output logic              mem_ren,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [ADDR_W:0] DEPTH_MAX = (ADDR_W+1)'(MAX_DEPTH);
    localparam logic [ADDR_W:0] DEPTH_MIN = (ADDR_W+1)'(2);

    logic [ADDR_W:0]   depth_reg;
    logic [ADDR_W-1:0] wptr_reg;
    logic [ADDR_W:0]   cnt_reg;
    logic              rd_pend_reg;
    logic [DATA_W-1:0] head_reg;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_valid_reg;

    logic              accept;
    logic              full;
    logic [ADDR_W-1:0] wptr_inc;
    logic [ADDR_W-1:0] wptr_next;
    logic [ADDR_W:0]   cnt_next;
    logic [ADDR_W:0]   depth_clamped;
    logic [DATA_W-1:0] oldest;

    assign accept = in_en & ~cfg_load;
    assign full   = (cnt_reg == depth_reg);

    always_comb begin
        wptr_inc = wptr_reg + 1'b1;
        // Full-size line wraps through natural counter overflow.
        if (depth_reg == DEPTH_MAX) begin
            wptr_next = wptr_inc;
        end else if ({1'b0, wptr_reg} == depth_reg - 1'b1) begin
            wptr_next = '0;
        end else begin
            wptr_next = wptr_inc;
        end
    end

    always_comb begin
        cnt_next = full ? cnt_reg : cnt_reg + 1'b1;
        if (cfg_depth < DEPTH_MIN) begin
            depth_clamped = DEPTH_MIN;
        end else if (cfg_depth > DEPTH_MAX) begin
            depth_clamped = DEPTH_MAX;
        end else begin
            depth_clamped = cfg_depth;
        end
        // Back-to-back accepts: the prefetch for this accept is still on the read port.
        oldest = rd_pend_reg ? mem_rdata : head_reg;
    end

    // Prefetch targets the slot the next accept will overwrite, i.e. the oldest entry.
    assign mem_wen   = accept;
    assign mem_waddr = wptr_reg;
    assign mem_wdata = in_data;
    assign mem_ren   = accept;
    assign mem_raddr = wptr_next;

    always_ff @(posedge clock) begin
        if (reset) begin
            depth_reg     <= DEPTH_MAX;
            wptr_reg      <= '0;
            cnt_reg       <= '0;
            rd_pend_reg   <= 1'b0;
            head_reg      <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
        end else if (cfg_load) begin
            depth_reg     <= depth_clamped;
            wptr_reg      <= '0;
            cnt_reg       <= '0;
            rd_pend_reg   <= 1'b0;
            head_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            rd_pend_reg <= accept;
            if (rd_pend_reg) begin
                head_reg <= mem_rdata;
            end
            if (accept) begin
                wptr_reg      <= wptr_next;
                cnt_reg       <= cnt_next;
                out_valid_reg <= 1'b1;
                out_data_reg  <= full ? oldest : '0;
            end else begin
                out_valid_reg <= 1'b0;
            end
        end
    end

    assign out_valid  = out_valid_reg;
    assign out_data   = out_data_reg;
    assign out_primed = full;

endmodule

// File: tb/tb_sdf_delay_line_ctrl.sv
// Bench for sdf_delay_line_ctrl: SRAM model, queue-based reference of the delay line,
// a constant vector table and directed plus random sequences.
module tb_sdf_delay_line_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic [8:0]  cfg_depth;
    logic        cfg_load;
    logic        in_en;
    logic [31:0] in_data;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_primed;
    logic [7:0]  mem_waddr;
    logic        mem_wen;
    logic [31:0] mem_wdata;
    logic [7:0]  mem_raddr;
    logic        mem_ren;
    logic [31:0] mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    sdf_delay_line_ctrl #(.DATA_W(32), .ADDR_W(8), .MAX_DEPTH(256)) dut (
        .clock(clock), .reset(reset), .cfg_depth(cfg_depth), .cfg_load(cfg_load),
        .in_en(in_en), .in_data(in_data), .out_valid(out_valid), .out_data(out_data),
        .out_primed(out_primed), .mem_waddr(mem_waddr), .mem_wen(mem_wen),
        .mem_wdata(mem_wdata), .mem_raddr(mem_raddr), .mem_ren(mem_ren),
        .mem_rdata(mem_rdata)
    );

    // 1R1W synchronous-read SRAM, one-cycle read latency.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hDEAD_0000 + i;
        mem_rdata = 32'h0;
    end
    always @(posedge clock) begin
        if (mem_wen) mem[mem_waddr] <= mem_wdata;
        if (mem_ren) mem_rdata <= mem[mem_raddr];
    end

    // Reference: every sample accepted since the last restart, in order.
    logic [31:0] hist [$];
    logic [31:0] obs  [$];
    int          depth = 256;
    logic        exp_valid;
    logic [31:0] exp_data;

    function automatic int clampd(input int c);
        return (c < 2) ? 2 : ((c > 256) ? 256 : c);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic cycle(input logic en, input logic [31:0] d, input logic ld, input logic [8:0] cd);
        int n;
        in_en = en; in_data = d; cfg_load = ld; cfg_depth = cd;
        #1;
        n = hist.size();
        if (en && !ld) begin
            chk("mem_wen", 32'(mem_wen), 32'd1);
            chk("mem_ren", 32'(mem_ren), 32'd1);
            chk("mem_waddr", 32'(mem_waddr), 32'(n % depth));
            chk("mem_raddr", 32'(mem_raddr), 32'((n + 1) % depth));
            chk("mem_wdata", mem_wdata, d);
            chk("addr_differ", 32'(mem_raddr != mem_waddr), 32'd1);
        end else begin
            chk("mem_wen_idle", 32'(mem_wen), 32'd0);
            chk("mem_ren_idle", 32'(mem_ren), 32'd0);
        end
        @(posedge clock);
        if (ld) begin
            depth = clampd(int'(cd));
            hist.delete();
            exp_valid = 1'b0;
        end else if (en) begin
            exp_valid = 1'b1;
            exp_data  = (n >= depth) ? hist[n - depth] : 32'h0;
            hist.push_back(d);
        end else begin
            exp_valid = 1'b0;
        end
        #1;
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        if (exp_valid) begin
            chk("out_data", out_data, exp_data);
            obs.push_back(out_data);
        end
        chk("out_primed", 32'(out_primed), 32'(hist.size() >= depth));
        $display("cyc en=%0d ld=%0d in=%0h -> valid=%0d data=%0h primed=%0d",
                 en, ld, d, out_valid, out_data, out_primed);
    endtask

    task automatic do_reset();
        reset = 1'b1; in_en = 1'b0; cfg_load = 1'b0;
        @(posedge clock);
        #1;
        depth = 256;
        hist.delete();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_out_primed", 32'(out_primed), 32'd0);
        reset = 1'b0;
    endtask

    typedef struct {
        logic        en;
        logic [31:0] data;
        logic        ld;
        logic [8:0]  cfg;
        logic        ev;
        logic [31:0] ed;
        logic        ep;
    } vec_t;

    vec_t tbl [10];

    initial begin
        logic [31:0] exp_seq [12];
        reset = 1'b1; cfg_depth = '0; cfg_load = 1'b0; in_en = 1'b0; in_data = '0;
        exp_valid = 1'b0; exp_data = '0;

        // Depth 2 bypass path, then a load that collides with an accept.
        tbl[0] = '{1'b0, 32'd0,  1'b1, 9'd2, 1'b0, 32'd0,  1'b0};
        tbl[1] = '{1'b1, 32'd10, 1'b0, 9'd0, 1'b1, 32'd0,  1'b0};
        tbl[2] = '{1'b1, 32'd20, 1'b0, 9'd0, 1'b1, 32'd0,  1'b1};
        tbl[3] = '{1'b1, 32'd30, 1'b0, 9'd0, 1'b1, 32'd10, 1'b1};
        tbl[4] = '{1'b1, 32'd40, 1'b0, 9'd0, 1'b1, 32'd20, 1'b1};
        tbl[5] = '{1'b0, 32'd0,  1'b0, 9'd0, 1'b0, 32'd0,  1'b1};
        tbl[6] = '{1'b1, 32'd99, 1'b1, 9'd2, 1'b0, 32'd0,  1'b0};
        tbl[7] = '{1'b1, 32'd5,  1'b0, 9'd0, 1'b1, 32'd0,  1'b0};
        tbl[8] = '{1'b1, 32'd6,  1'b0, 9'd0, 1'b1, 32'd0,  1'b1};
        tbl[9] = '{1'b1, 32'd7,  1'b0, 9'd0, 1'b1, 32'd5,  1'b1};

        do_reset();
        do_reset();

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].en, tbl[i].data, tbl[i].ld, tbl[i].cfg);
            chk($sformatf("tbl%0d_valid", i), 32'(out_valid), 32'(tbl[i].ev));
            if (tbl[i].ev) chk($sformatf("tbl%0d_data", i), out_data, tbl[i].ed);
            chk($sformatf("tbl%0d_primed", i), 32'(out_primed), 32'(tbl[i].ep));
        end

        for (int i = 0; i < 12; i++) exp_seq[i] = (i < 4) ? 32'd0 : 32'(i - 3);

        // Depth 4 continuous.
        cycle(1'b0, 0, 1'b1, 9'd4);
        obs.delete();
        for (int k = 1; k <= 12; k++) cycle(1'b1, 32'(k), 1'b0, 9'd0);
        chk("cont_count", 32'(obs.size()), 32'd12);
        for (int i = 0; i < 12 && i < obs.size(); i++) chk($sformatf("cont_seq%0d", i), obs[i], exp_seq[i]);

        // Depth 4 with random idle gaps.
        cycle(1'b0, 0, 1'b1, 9'd4);
        obs.delete();
        for (int k = 1; k <= 12; k++) begin
            cycle(1'b1, 32'(k), 1'b0, 9'd0);
            repeat ($urandom_range(1, 5)) cycle(1'b0, $urandom, 1'b0, 9'd0);
        end
        chk("gap_count", 32'(obs.size()), 32'd12);
        for (int i = 0; i < 12 && i < obs.size(); i++) chk($sformatf("gap_seq%0d", i), obs[i], exp_seq[i]);

        // Depth 256, several wraps.
        cycle(1'b0, 0, 1'b1, 9'd256);
        for (int k = 0; k < 600; k++) cycle(1'b1, 32'(k), 1'b0, 9'd0);
        chk("d256_last", out_data, 32'd343);

        // Reconfigure mid-stream, load colliding with an accept.
        cycle(1'b0, 0, 1'b1, 9'd8);
        for (int k = 0; k < 10; k++) cycle(1'b1, 32'(100 + k), 1'b0, 9'd0);
        cycle(1'b1, 32'd999, 1'b1, 9'd3);
        obs.delete();
        for (int k = 0; k < 6; k++) cycle(1'b1, 32'(200 + k), 1'b0, 9'd0);
        if (obs.size() == 6) begin
            chk("recfg_0", obs[0], 32'd0);
            chk("recfg_2", obs[2], 32'd0);
            chk("recfg_3", obs[3], 32'd200);
            chk("recfg_5", obs[5], 32'd202);
        end else begin
            chk("recfg_count", 32'(obs.size()), 32'd6);
        end

        // Reset mid-stream; default depth must be 256.
        for (int k = 0; k < 5; k++) cycle(1'b1, $urandom, 1'b0, 9'd0);
        do_reset();
        for (int k = 0; k < 260; k++) cycle(1'b1, $urandom, 1'b0, 9'd0);

        // Clamping.
        cycle(1'b0, 0, 1'b1, 9'd1);
        for (int k = 0; k < 8; k++) cycle(1'b1, $urandom, 1'b0, 9'd0);
        cycle(1'b0, 0, 1'b1, 9'd0);
        for (int k = 0; k < 6; k++) cycle(1'b1, $urandom, 1'b0, 9'd0);
        cycle(1'b0, 0, 1'b1, 9'd300);
        for (int k = 0; k < 270; k++) cycle(1'b1, $urandom, 1'b0, 9'd0);

        // Random traffic, occasional reloads with arbitrary depths.
        for (int k = 0; k < 4000; k++) begin
            logic        ld;
            logic [8:0]  cd;
            ld = ($urandom_range(0, 149) == 0);
            cd = ($urandom_range(0, 1) == 0) ? 9'($urandom_range(0, 12)) : 9'($urandom_range(0, 511));
            cycle($urandom_range(0, 2) != 0, $urandom, ld, cd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sdf_delay_line_ctrl.md
Name: sdf_delay_line_ctrl

Overview:
- Controller that turns a 1R1W synchronous-read SRAM (one-cycle read latency, read/write on different addresses per cycle) into a programmable-depth circular delay line.
- Used as the feedback delay of an SDF radix-2^2 FFT stage: the butterfly pushes one sample per enabled cycle and gets back the sample pushed exactly `depth` accepts earlier.
- Sits between the stage datapath and the memory macro wrapper, and drives that wrapper's R0/W0 ports directly.

Parameters:
- DATA_W, 32, sample width (complex pair, packed).
- ADDR_W, 8, memory address width.
- MAX_DEPTH, 256, largest supported delay; must equal 2^ADDR_W.

Ports:
- clock  in  1  single clock; memory R0_clk/W0_clk are tied to it.
- reset  in  1  synchronous, active-high.
- cfg_depth  in  ADDR_W+1  delay length D in accepts; legal range 2..MAX_DEPTH.
- cfg_load  in  1  pulse: latch cfg_depth, restart the line.
- in_en  in  1  accept one sample this cycle.
- in_data  in  DATA_W  sample to push.
- out_valid  out  1  one-cycle pulse, cycle after each accept.
- out_data  out  DATA_W  delayed sample.
- out_primed  out  1  high once D samples have been accepted since the last restart.
- mem_waddr  out  ADDR_W  to W0_addr.
- mem_wen  out  1  to W0_en.
- mem_wdata  out  DATA_W  to W0_data.
- mem_raddr  out  ADDR_W  to R0_addr.
- mem_ren  out  1  to R0_en.
- mem_rdata  in  DATA_W  from R0_data; valid the cycle after mem_ren.

Behaviour:
- **Registers:** depth_q, wptr (0..D-1), cnt (saturates at D), rd_pend, head, out_data, out_valid.
- **Reset values:**
  - depth_q = MAX_DEPTH.
  - wptr = 0, cnt = 0, rd_pend = 0, head = 0.
  - out_valid = 0, out_data = 0, out_primed = 0.
- **States:**
  - FILL (cnt < D): out_data outputs are zero.
  - RUN (cnt == D).
  - Reset and cfg_load both enter FILL.
- **Accept** (in_en = 1, no cfg_load):
  - Write: mem_wen = 1, mem_waddr = wptr, mem_wdata = in_data (combinational).
  - Prefetch: mem_ren = 1, mem_raddr = (wptr == D-1) ? 0 : wptr+1 (combinational). This fetches the oldest entry for the next accept. Read and write addresses always differ because D >= 2.
  - Pointer: wptr <= wrap(wptr+1); cnt <= min(cnt+1, D).
  - Output: out_valid <= 1. out_data <= (cnt == D) ? oldest : 0, where oldest = rd_pend ? mem_rdata : head (bypass for back-to-back accepts).
- **No accept:**
  - mem_wen = 0, mem_ren = 0.
  - out_valid <= 0; out_data holds.
- **Head capture:** rd_pend <= mem_ren. When rd_pend = 1, head <= mem_rdata. Gaps of any length between accepts therefore preserve the prefetched value.
- **Latency:** out_data/out_valid appear 1 cycle after the accept. Effective delay = exactly D accepts, independent of gaps.
- **out_primed:** combinational (cnt == D).
- **cfg_load:**
  - Has priority over in_en in the same cycle; that sample is dropped (no write).
  - depth_q <= cfg_depth; wptr, cnt, rd_pend, head cleared; out_valid <= 0.
  - Memory contents are not cleared; stale data is masked because the line is back in FILL.
- **Illegal cfg_depth** (< 2 or > MAX_DEPTH): clamp to 2 or MAX_DEPTH respectively.
- **Reset mid-stream:** same clearing as cfg_load, plus depth_q = MAX_DEPTH. Any read in flight is discarded.
- **Wrap:** D = MAX_DEPTH uses natural ADDR_W overflow; any other D uses an explicit compare against D-1.
- **Width rule:** no arithmetic on data; data passes through bit-exact.

Test Plan:
- **Depth 4, continuous:** cfg_load with depth 4, then in_en every cycle with data 1..12 -> out_valid every cycle starting 1 cycle after the first accept. out_data = 0,0,0,0,1,2,...,8. out_primed rises on the cycle after the 4th accept.
- **Depth 4, random gaps (1-5 idle cycles), data 1..12** -> identical out_data sequence to the continuous case, once per out_valid. No out_valid during gaps.
- **Depth 2, back-to-back (bypass path):** data 10,20,30,40 -> out_data 0,0,10,20.
- **Depth 256:** 600 accepts with data = index -> accept k (k >= 256) outputs k-256; wptr wraps 255->0 with no glitch. mem_raddr != mem_waddr whenever both enables are high.
- **Reconfigure mid-stream:** after 10 accepts at depth 8, cfg_load with depth 3 in the same cycle as an in_en -> that sample is not written. The next 3 outputs are 0, then the new data appears delayed by 3.
- **Reset mid-stream and clamping:** assert reset during streaming -> all outputs 0 the next cycle and depth_q = 256. Then cfg_depth = 1 -> behaves as depth 2; cfg_depth = 300 -> behaves as 256.
